pu_msp430_timer16_bank: RTL and testbench



---
 rtl/pu_msp430_timer16_bank_if.sv | 17 +
 rtl/pu_msp430_timer16_bank.sv | 167 ++++++++++++++++
 tb/tb_pu_msp430_timer16_bank.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_msp430_timer16_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : pu_msp430_timer16_bank_if
// Purpose  : MSP430 per_* peripheral bus bundle used by the timer bank.
// Revision : 1.0 - initial release
// ============================================================================
interface pu_msp430_timer16_bank_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface
`default_nettype wire

// File: rtl/pu_msp430_timer16_bank.sv
`default_nettype none
// ============================================================================
// Module   : pu_msp430_timer16_bank
// Purpose  : 16-bit timer with NCH compare channels on the MSP430 per_* bus.
//            Prescaler built only when PU_MSP430_TIMER16_PRESCALER_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module pu_msp430_timer16_bank #(
    parameter logic [14:0] BASE_ADDR = 15'h0190,
    parameter int          DEC_WD    = 4,
    parameter int          NCH       = 2
) (
    input  wire                     mclk,
    input  wire                     puc_rst,
    pu_msp430_timer16_bank_if.slave bus,
    output logic                    irq,
    output logic [NCH-1:0]          cmp_match
);

    localparam int                 c_IDX_W    = DEC_WD - 1;
    localparam logic [c_IDX_W-1:0] c_IDX_CTRL = c_IDX_W'(0);
    localparam logic [c_IDX_W-1:0] c_IDX_CNT  = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_STAT = c_IDX_W'(2);

    function automatic logic [15:0] f_merge(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  lanes);
        f_merge = {lanes[1] ? new_v[15:8] : old_v[15:8],
                   lanes[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

    logic               r_en;
    logic               r_ie;
    logic               r_mode;
    logic [15:0]        r_cnt;
    logic [NCH-1:0]     r_stat;
    logic [15:0]        r_cmp [NCH];
    logic [NCH-1:0]     r_match;

    logic               w_sel;
    logic               w_wr;
    logic               w_rd;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_ctrl_wr;
    logic               w_clr;
    logic               w_cnt_wr;
    logic               w_stat_wr;
    logic               w_tick;
    logic [1:0]         w_psc;
    logic [NCH-1:0]     w_match;
    logic [NCH-1:0]     w_stat_clr;
    logic [15:0]        w_rdata;

    assign w_sel     = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign w_wr      = w_sel & (|bus.per_we);
    assign w_rd      = w_sel & ~(|bus.per_we);
    assign w_idx     = bus.per_addr[DEC_WD-2:0];
    assign w_ctrl_wr = w_wr & bus.per_we[0] & (w_idx == c_IDX_CTRL);
    assign w_clr     = w_ctrl_wr & bus.per_din[1];
    assign w_cnt_wr  = w_wr & (w_idx == c_IDX_CNT);
    assign w_stat_wr = w_wr & (w_idx == c_IDX_STAT);

`ifdef PU_MSP430_TIMER16_PRESCALER_EN
    logic [1:0] r_psc;
    logic [2:0] r_presc;
    logic [2:0] w_presc_max;

    // ">=" lets a shrunken PSC take effect at once instead of wrapping the counter
    assign w_presc_max = 3'((4'd1 << r_psc) - 4'd1);
    assign w_tick      = r_en & (r_presc >= w_presc_max);
    assign w_psc       = r_psc;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_psc   <= 2'b00;
            r_presc <= 3'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_psc <= bus.per_din[5:4];
            end
            if (!r_en || w_clr || w_tick) begin
                r_presc <= 3'd0;
            end else begin
                r_presc <= r_presc + 3'd1;
            end
        end
    end
`else
    assign w_tick = r_en;
    assign w_psc  = 2'b00;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_match
            assign w_match[gi] = w_tick & (r_cnt == r_cmp[gi]);
        end
    endgenerate

    always_comb begin
        w_stat_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_stat_wr && bus.per_we[i/8] && bus.per_din[i]) begin
                w_stat_clr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_mode  <= 1'b0;
            r_cnt   <= 16'h0000;
            r_stat  <= '0;
            r_match <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cmp[i] <= 16'h0000;
            end
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= bus.per_din[0];
                r_ie   <= bus.per_din[2];
                r_mode <= bus.per_din[3];
            end

            if (w_clr) begin
                r_cnt <= 16'h0000;
            end else if (w_cnt_wr) begin
                r_cnt <= f_merge(r_cnt, bus.per_din, bus.per_we);
            end else if (w_tick) begin
                r_cnt <= (r_mode && (r_cnt == r_cmp[0])) ? 16'h0000 : r_cnt + 16'h0001;
            end

            // hardware set is OR-ed in after the clear so it wins a same-cycle W1C
            r_stat  <= (r_stat & ~w_stat_clr) | w_match;
            r_match <= w_match;

            for (int i = 0; i < NCH; i++) begin
                if (w_wr && (w_idx == c_IDX_W'(3 + i))) begin
                    r_cmp[i] <= f_merge(r_cmp[i], bus.per_din, bus.per_we);
                end
            end
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        if (w_idx == c_IDX_CTRL) begin
            w_rdata = {10'b0, w_psc, r_mode, r_ie, 1'b0, r_en};
        end else if (w_idx == c_IDX_CNT) begin
            w_rdata = r_cnt;
        end else if (w_idx == c_IDX_STAT) begin
            w_rdata = 16'(r_stat);
        end
        for (int i = 0; i < NCH; i++) begin
            if (w_idx == c_IDX_W'(3 + i)) begin
                w_rdata = r_cmp[i];
            end
        end
    end

    assign bus.per_dout = w_rd ? w_rdata : 16'h0000;
    assign irq          = r_ie & (|r_stat);
    assign cmp_match    = r_match;

endmodule
`default_nettype wire

// File: tb/tb_pu_msp430_timer16_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_msp430_timer16_bank
// Purpose  : Directed + randomized bench for pu_msp430_timer16_bank with a
//            register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_msp430_timer16_bank;

    localparam logic [14:0] BASE_ADDR = 15'h0190;
    localparam int          DEC_WD    = 4;
    localparam int          NCH       = 2;
    localparam int          NWORD     = 1 << (DEC_WD - 1);
`ifdef PU_MSP430_TIMER16_PRESCALER_EN
    localparam bit          PSC_ON    = 1'b1;
`else
    localparam bit          PSC_ON    = 1'b0;
`endif

    logic           mclk    = 1'b0;
    logic           puc_rst = 1'b1;
    logic           irq;
    logic [NCH-1:0] cmp_match;
    int             checks  = 0;
    int             errors  = 0;

    pu_msp430_timer16_bank_if bus ();

    pu_msp430_timer16_bank #(
        .BASE_ADDR (BASE_ADDR),
        .DEC_WD    (DEC_WD),
        .NCH       (NCH)
    ) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .bus       (bus),
        .irq       (irq),
        .cmp_match (cmp_match)
    );

    always #5 mclk = ~mclk;

    // Reference model: the register file as plain variables
    bit             m_en, m_ie, m_mode;
    int             m_psc, m_pc;
    logic [15:0]    m_cnt;
    logic [15:0]    m_cmp [NCH];
    logic [NCH-1:0] m_stat, m_match;

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_mode = 0; m_psc = 0; m_pc = 0;
        m_cnt = 16'h0; m_stat = '0; m_match = '0;
        for (int i = 0; i < NCH; i++) m_cmp[i] = 16'h0;
    endtask

    function automatic bit in_range(input logic [13:0] addr);
        return (addr >> (DEC_WD - 1)) == 14'(BASE_ADDR >> DEC_WD);
    endfunction

    function automatic int word_of(input logic [13:0] addr);
        return int'(addr) % NWORD;
    endfunction

    function automatic logic [13:0] addr_of(input int w);
        return 14'(BASE_ADDR >> 1) + 14'(w);
    endfunction

    function automatic logic [15:0] lanes(input logic [15:0] o, input logic [15:0] n, input logic [1:0] we);
        logic [15:0] r;
        r = o;
        if (we[0]) r[7:0]  = n[7:0];
        if (we[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    function automatic logic [15:0] model_read(input logic en, input logic [13:0] addr, input logic [1:0] we);
        int w;
        if (!(en && we == 2'b00 && in_range(addr))) return 16'h0;
        w = word_of(addr);
        if (w == 0) return {10'b0, 2'(m_psc), m_mode, m_ie, 1'b0, m_en};
        if (w == 1) return m_cnt;
        if (w == 2) return 16'(m_stat);
        if (w >= 3 && w < 3 + NCH) return m_cmp[w-3];
        return 16'h0;
    endfunction

    task automatic model_step(input logic en, input logic [13:0] addr, input logic [15:0] din, input logic [1:0] we);
        bit             wr, tick, clr;
        int             w, period;
        logic [NCH-1:0] hit;
        logic [15:0]    ncnt;
        wr     = en && in_range(addr) && (we != 2'b00);
        w      = word_of(addr);
        period = 1 << m_psc;
        tick   = m_en && (m_pc + 1 >= period);
        clr    = wr && w == 0 && we[0] && din[1];
        for (int i = 0; i < NCH; i++) hit[i] = tick && (m_cnt == m_cmp[i]);

        if (clr)                ncnt = 16'h0;
        else if (wr && w == 1)  ncnt = lanes(m_cnt, din, we);
        else if (tick)          ncnt = (m_mode && m_cnt == m_cmp[0]) ? 16'h0 : m_cnt + 16'h1;
        else                    ncnt = m_cnt;

        m_pc = (!m_en || clr || tick) ? 0 : m_pc + 1;
        for (int i = 0; i < NCH; i++)
            if (wr && w == 2 && we[i/8] && din[i]) m_stat[i] = 1'b0;
        m_stat = m_stat | hit;
        for (int i = 0; i < NCH; i++)
            if (wr && w == 3 + i) m_cmp[i] = lanes(m_cmp[i], din, we);
        if (wr && w == 0 && we[0]) begin
            m_en   = din[0];
            m_ie   = din[2];
            m_mode = din[3];
            m_psc  = PSC_ON ? int'(din[5:4]) : 0;
        end
        m_cnt   = ncnt;
        m_match = hit;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle, entered and left on a falling edge; DUT checked against the model
    task automatic step(input logic en, input logic [13:0] addr, input logic [15:0] din,
                        input logic [1:0] we, output logic [15:0] rdata);
        bus.per_en   = en;
        bus.per_addr = addr;
        bus.per_din  = din;
        bus.per_we   = we;
        #1;
        rdata = bus.per_dout;
        check("per_dout", rdata, model_read(en, addr, we));
        @(posedge mclk);
        model_step(en, addr, din, we);
        @(negedge mclk);
        check("irq", 16'(irq), 16'(m_ie && (|m_stat)));
        check("cmp_match", 16'(cmp_match), 16'(m_match));
    endtask

    task automatic wr(input int w, input logic [15:0] d, input logic [1:0] we);
        logic [15:0] r;
        step(1'b1, addr_of(w), d, we, r);
    endtask

    task automatic rd_chk(input int w, input logic [15:0] exp, input string name);
        logic [15:0] r;
        step(1'b1, addr_of(w), 16'h0, 2'b00, r);
        check(name, r, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.per_en = 1'b0; bus.per_addr = '0; bus.per_din = '0; bus.per_we = 2'b00;
        model_reset();
        repeat (3) @(negedge mclk);
        puc_rst = 1'b0;
        check("reset_irq", 16'(irq), 16'h0);
        check("reset_cmp_match", 16'(cmp_match), 16'h0);
        for (int w = 0; w < NWORD; w++) rd_chk(w, 16'h0000, "reset_read");

        // CH0 match at 5, irq, W1C
        wr(4, 16'h1234, 2'b11);
        wr(3, 16'h0005, 2'b11);
        wr(0, 16'h0005, 2'b11);
        for (int k = 0; k < 6; k++) rd_chk(1, 16'(k), "cnt_run_to_5");
        check("match5_pulse", 16'(cmp_match), 16'h0001);
        check("match5_irq", 16'(irq), 16'h1);
        rd_chk(2, 16'h0001, "stat_after_match5");
        check("match5_pulse_gone", 16'(cmp_match), 16'h0000);
        wr(2, 16'h0001, 2'b01);
        check("irq_after_w1c", 16'(irq), 16'h0);

        // Up mode to CMP0=3
        wr(0, 16'h0000, 2'b11);
        wr(1, 16'h0000, 2'b11);
        wr(3, 16'h0003, 2'b11);
        wr(0, 16'h0009, 2'b11);
        for (int k = 0; k < 8; k++) rd_chk(1, 16'(k % 4), "cnt_up_mode");

        // Wrap in continuous mode, CH1 at 0xFFFF
        wr(0, 16'h0000, 2'b11);
        wr(1, 16'hFFFE, 2'b11);
        wr(4, 16'hFFFF, 2'b11);
        wr(2, 16'hFFFF, 2'b11);
        wr(0, 16'h0001, 2'b11);
        rd_chk(1, 16'hFFFE, "cnt_fffe");
        rd_chk(1, 16'hFFFF, "cnt_ffff");
        rd_chk(1, 16'h0000, "cnt_wrap");
        rd_chk(2, 16'h0002, "stat_ch1_wrap");

        // W1C colliding with a CH0 match
        wr(0, 16'h0000, 2'b11);
        wr(2, 16'hFFFF, 2'b11);
        wr(1, 16'h0000, 2'b11);
        wr(3, 16'h0002, 2'b11);
        wr(0, 16'h0001, 2'b11);
        rd_chk(1, 16'h0000, "cnt_c0");
        rd_chk(1, 16'h0001, "cnt_c1");
        wr(2, 16'h0001, 2'b01);
        check("collide_pulse", 16'(cmp_match), 16'h0001);
        rd_chk(2, 16'h0001, "stat_set_wins");

        // CLR strobe while counting
        wr(0, 16'h0003, 2'b01);
        rd_chk(1, 16'h0000, "cnt_after_clr");
        rd_chk(0, 16'h0001, "ctrl_clr_reads_0");

        // Byte lanes
        wr(0, 16'h0000, 2'b11);
        wr(1, 16'h0034, 2'b11);
        wr(1, 16'hAB00, 2'b10);
        rd_chk(1, 16'hAB34, "cnt_hi_lane");
        wr(1, 16'hCD56, 2'b01);
        rd_chk(1, 16'hAB56, "cnt_lo_lane");
        wr(0, 16'h0031, 2'b11);
        rd_chk(0, PSC_ON ? 16'h0031 : 16'h0001, "ctrl_psc_field");
        wr(0, 16'h0000, 2'b11);
        wr(1, 16'h0000, 2'b11);
`ifdef PU_MSP430_TIMER16_PRESCALER_EN
        wr(0, 16'h0021, 2'b11);
        for (int k = 0; k < 8; k++) rd_chk(1, (k < 4) ? 16'h0000 : 16'h0001, "cnt_psc2");
        wr(1, 16'hAB00, 2'b10);
        rd_chk(1, 16'hAB02, "cnt_hi_lane_counting");
`else
        wr(0, 16'h0001, 2'b11);
        for (int k = 0; k < 3; k++) rd_chk(1, 16'(k), "cnt_nopsc");
        wr(1, 16'hAB00, 2'b10);
        rd_chk(1, 16'hAB03, "cnt_hi_lane_counting");
`endif

        // Asynchronous reset mid-count
        wr(0, 16'h0005, 2'b11);
        check("irq_before_reset", 16'(irq), 16'h1);
        bus.per_en = 1'b1; bus.per_addr = addr_of(1); bus.per_we = 2'b00;
        #3 puc_rst = 1'b1;
        #1;
        check("async_rst_irq", 16'(irq), 16'h0);
        check("async_rst_cmp_match", 16'(cmp_match), 16'h0);
        check("async_rst_cnt", bus.per_dout, 16'h0000);
        model_reset();
        @(negedge mclk);
        puc_rst = 1'b0;
        rd_chk(1, 16'h0000, "cnt_held_after_rst");
        rd_chk(1, 16'h0000, "cnt_held_after_rst");
        rd_chk(0, 16'h0000, "ctrl_after_rst");

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [13:0] a;
            logic [15:0] d, r;
            logic [1:0]  we;
            logic        en;
            int          w;
            w  = $urandom_range(0, NWORD - 1);
            a  = addr_of(w);
            if ($urandom_range(0, 19) == 0) a = 14'($urandom);
            en = ($urandom_range(0, 9) != 0);
            we = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            d  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (w == 0) begin
                d[0] = ($urandom_range(0, 7) != 0);
                d[1] = ($urandom_range(0, 31) == 0);
            end
            if (w == 1 && $urandom_range(0, 3) != 0) we = 2'b00;
            step(en, a, d, we, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
